// File: rtl/lc_stream_pkg.sv
// Shared definitions for the loopback-splitter stream path: word layout and
// the width helper used for pointer and occupancy sizing.
package lc_stream_pkg;

  localparam int LC_DATA_W = 72;
  localparam int LC_CTRL_W = 8;

  // One XGMII beat: 8 control bits on top of 64 data bits.
  typedef struct packed {
    logic [LC_CTRL_W-1:0]           ctrl;
    logic [LC_DATA_W-LC_CTRL_W-1:0] data;
  } lc_word_t;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int lc_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lc_splitter_elastic_fifo_if.sv
// Stream bundle around the elastic FIFO.
//
// Handshake: the ingress side is valid-only. A word is offered whenever
// in_valid is high, and nothing is returned to the source. The egress side is
// ready/valid. A word transfers on a rising edge where out_valid and out_ready
// are both high. out_valid does not depend on out_ready, and out_data stays
// stable while out_valid is high and out_ready is low.
interface lc_splitter_elastic_fifo_if #(
  parameter int DATA_W = 72
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Producer/consumer side: drives the ingress stream and the egress accept.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  // FIFO side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/lc_elastic_ram.sv
// DEPTH x DATA_W storage for the elastic FIFO. Writes are synchronous and
// reads are asynchronous, so the FIFO head is visible without a read cycle.
// The storage is deliberately not reset.
module lc_elastic_ram #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: capture the word at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Show-ahead read port.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lc_splitter_elastic_fifo.sv
// Elastic buffer ahead of the loopback splitter timing adapter. That adapter
// cannot stall its source, so this block absorbs out_ready drops. When the
// buffer is full and no pop frees a slot, the incoming word is dropped and
// counted.
module lc_splitter_elastic_fifo
  import lc_stream_pkg::*;
#(
  parameter int DATA_W       = LC_DATA_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter int CNT_W        = 16,
  localparam int AW          = lc_clog2(DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  lc_splitter_elastic_fifo_if.slave   bus,
  output logic [LW-1:0]               fill_level,
  output logic                        almost_full,
  output logic                        overflow,
  output logic [CNT_W-1:0]            drop_cnt,
  input  logic                        clear_stats
);

  localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_AFULL = LW'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q,  count_d;
  logic              afull_q,  afull_d;
  logic              ovf_q,    ovf_d;
  logic [CNT_W-1:0]  drops_q,  drops_d;
  logic              push, pop, full, drop;
  logic [DATA_W-1:0] rd_word;

  lc_elastic_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  // Handshake decode, pointer/level next state and drop statistics.
  // A pop frees the head slot on the same edge, so a full FIFO still accepts
  // a write when the consumer is taking a word.
  always_comb begin
    pop  = (count_q != '0) && bus.out_ready;
    full = (count_q == LVL_FULL);
    push = bus.in_valid && (!full || pop);
    drop = bus.in_valid && !push;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    afull_d = (count_d >= LVL_AFULL);

    // Clear first, then account for a drop in the same cycle.
    ovf_d   = clear_stats ? 1'b0 : ovf_q;
    drops_d = clear_stats ? '0 : drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != CNT_MAX) begin
        drops_d = drops_d + 1'b1;
      end
    end
  end

  // State registers. Reset discards contents and overrides everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
    end
  end

  // The head word is forced to zero while empty so that reset shows a
  // defined output even though the storage itself is not reset.
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? rd_word : '0;
  assign fill_level    = count_q;
  assign almost_full   = afull_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = drops_q;

endmodule

// File: tb/tb_lc_splitter_elastic_fifo.sv
// Bench for the elastic FIFO: directed phases plus a random phase, all
// scored against a queue model of the buffer and its drop statistics.
module tb_lc_splitter_elastic_fifo;
  import lc_stream_pkg::*;

  localparam int W     = 72;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int CNT_W = 4;
  localparam int LW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_stats = 1'b0;
  logic [LW-1:0]    fill_level;
  logic             almost_full;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  lc_splitter_elastic_fifo_if #(.DATA_W(W)) bus ();

  lc_splitter_elastic_fifo #(
    .DATA_W       (W),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL),
    .CNT_W        (CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .fill_level  (fill_level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .clear_stats (clear_stats)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_drops = '0;
  int               m_drop_total = 0;
  int               recv = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int n);
    lc_word_t w;
    w.ctrl = 8'(n) ^ 8'h5A;
    w.data = 64'hC0DE_0000_0000_0000 | 64'(n);
    return w;
  endfunction

  // Compare DUT outputs against the model, then advance the model by the
  // edge that follows. Inputs are stable here; the DUT samples them next edge.
  always @(negedge clk) begin
    int  sz;
    logic m_pop, m_push;
    sz = exp_q.size();
    check_eq("out_valid",   W'(bus.out_valid), W'(sz != 0));
    check_eq("fill_level",  W'(fill_level),    W'(sz));
    check_eq("almost_full", W'(almost_full),   W'(sz >= AFULL));
    check_eq("overflow",    W'(overflow),      W'(m_ovf));
    check_eq("drop_cnt",    W'(drop_cnt),      W'(m_drops));
    m_pop = (sz != 0) && bus.out_ready;
    if (m_pop) begin
      check_eq("out_data", bus.out_data, exp_q[0]);
    end
    if (reset) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_drops = '0;
    end else begin
      m_push = bus.in_valid && ((sz < DEPTH) || m_pop);
      if (m_pop) begin
        void'(exp_q.pop_front());
        recv = recv + 1;
      end
      if (m_push) exp_q.push_back(bus.in_data);
      if (clear_stats) begin
        m_ovf   = 1'b0;
        m_drops = '0;
      end
      if (bus.in_valid && !m_push) begin
        m_ovf = 1'b1;
        if (m_drops != {CNT_W{1'b1}}) m_drops = m_drops + 1'b1;
        m_drop_total = m_drop_total + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      drive(1'b0, '0, 1'b1);
      guard = guard + 1;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", W'(exp_q.size()), '0);
    idle(1, 1'b1);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) drive(1'b1, mk(base + i), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int peak;
    int sent;
    int recv0;
    int drops0;
    int gap;
    int guard;
    logic v;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    idle(3, 1'b0);
    reset = 1'b0;

    // Reset state.
    check_eq("rst_valid", W'(bus.out_valid), '0);
    check_eq("rst_level", W'(fill_level), '0);
    check_eq("rst_data",  bus.out_data, '0);

    // Streaming with the consumer always ready: one-cycle latency, level <= 1.
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, mk(i), 1'b1);
      if (i == 1) check_eq("t1_latency", W'(bus.out_valid), W'(1));
      if (int'(fill_level) > peak) peak = int'(fill_level);
    end
    drain();
    check_eq("t1_peak",  W'(peak), W'(1));
    check_eq("t1_ovf",   W'(overflow), '0);
    check_eq("t1_recv",  W'(recv), W'(5));

    // Fill to full with the consumer stalled, then one dropped word.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(100 + i), 1'b0);
      check_eq("t2_afull", W'(almost_full), W'((i + 1) >= AFULL));
    end
    check_eq("t2_full_level", W'(fill_level), W'(DEPTH));
    drive(1'b1, mk(200), 1'b0);
    check_eq("t2_drop_cnt", W'(drop_cnt), W'(1));
    check_eq("t2_ovf",      W'(overflow), W'(1));
    check_eq("t2_level",    W'(fill_level), W'(DEPTH));
    recv0 = recv;
    drain();
    check_eq("t2_drained", W'(recv - recv0), W'(DEPTH));

    // Full with simultaneous push and pop: no drops, level pinned at DEPTH.
    fill(DEPTH, 300);
    recv0 = recv;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(400 + i), 1'b1);
      check_eq("t3_level", W'(fill_level), W'(DEPTH));
    end
    check_eq("t3_pops",     W'(recv - recv0), W'(10));
    check_eq("t3_drop_cnt", W'(drop_cnt), W'(1));

    // Saturation of the 4-bit drop counter, clear, and clear with a drop.
    for (int i = 0; i < 20; i++) drive(1'b1, mk(500 + i), 1'b0);
    check_eq("t4_sat", W'(drop_cnt), W'(15));
    clear_stats = 1'b1;
    drive(1'b0, '0, 1'b0);
    clear_stats = 1'b0;
    check_eq("t4_clr_cnt", W'(drop_cnt), '0);
    check_eq("t4_clr_ovf", W'(overflow), '0);
    clear_stats = 1'b1;
    drive(1'b1, mk(600), 1'b0);
    clear_stats = 1'b0;
    check_eq("t4_cd_cnt", W'(drop_cnt), W'(1));
    check_eq("t4_cd_ovf", W'(overflow), W'(1));
    drain();

    // Random traffic across pointer wrap; any loss must equal the drop count.
    clear_stats = 1'b1;
    idle(1, 1'b0);
    clear_stats = 1'b0;
    recv0  = recv;
    drops0 = m_drop_total;
    sent   = 0;
    guard  = 0;
    while (sent < 100 && guard < 1000) begin
      v = ($urandom_range(0, 9) < 7);
      drive(v, mk(1000 + sent), 1'($urandom_range(0, 1)));
      if (v) sent = sent + 1;
      guard = guard + 1;
    end
    if (sent < 100) check_eq("t5_send_timeout", W'(sent), W'(100));
    drain();
    gap = sent - (recv - recv0);
    check_eq("t5_gap_vs_model", W'(gap), W'(m_drop_total - drops0));
    check_eq("t5_drop_cnt", W'(drop_cnt), W'((gap > 15) ? 15 : gap));

    // Reset mid-operation with a word offered: contents and stats discarded.
    fill(DEPTH, 2000);
    drive(1'b1, mk(2100), 1'b0);
    drain();
    fill(9, 3000);
    check_eq("t6_pre_level", W'(fill_level), W'(9));
    reset = 1'b1;
    drive(1'b1, mk(3100), 1'b0);
    reset = 1'b0;
    check_eq("t6_level", W'(fill_level), '0);
    check_eq("t6_valid", W'(bus.out_valid), '0);
    check_eq("t6_ovf",   W'(overflow), '0);
    check_eq("t6_cnt",   W'(drop_cnt), '0);
    recv0 = recv;
    for (int i = 0; i < 3; i++) drive(1'b1, mk(4000 + i), 1'b1);
    drain();
    check_eq("t6_recv", W'(recv - recv0), W'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
